// File: rtl/register_file_mp_pkg.sv
// Shared types and default sizes for the multi-port register file.
// Holds the clear/ready state enum and default width/depth constants.
package rv32_regfile_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_WORDS      = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file.
// Ports: ready_i gate, idx_i index, bank_i storage, byp_* forwarding, data_o.
module regfile_read_port #(
    parameter int DATA_WIDTH  = 32,
    parameter int WORDS       = 32,
    parameter int SELECT_SIZE = 5,
    parameter bit ZERO_REG    = 1'b1
) (
    input  logic                   ready_i,
    input  logic [SELECT_SIZE-1:0] idx_i,
    input  logic [DATA_WIDTH-1:0]  bank_i [WORDS],
    input  logic                   byp_en_i,
    input  logic [SELECT_SIZE-1:0] byp_idx_i,
    input  logic [DATA_WIDTH-1:0]  byp_data_i,
    output logic [DATA_WIDTH-1:0]  data_o
);

    localparam logic [SELECT_SIZE:0] WORDS_W = (SELECT_SIZE+1)'(WORDS);

    logic idx_valid;
    logic idx_zero;

    assign idx_valid = ({1'b0, idx_i} < WORDS_W);
    assign idx_zero  = ZERO_REG && (idx_i == '0);

    always_comb begin
        data_o = '0;
        if (!ready_i || !idx_valid || idx_zero) begin
            data_o = '0;
        end else if (byp_en_i && (idx_i == byp_idx_i)) begin
            data_o = byp_data_i;
        end else begin
            data_o = bank_i[idx_i];
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file that zeroes itself after reset before use.
// Ports: clk_i, reset_ni, reg_we_ni/data_i/reg_dst_i write, reg_src_i/src_o reads, ready_o, drop_o.
module register_file_mp
    import rv32_regfile_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int WORDS       = DEF_WORDS,
    parameter int SELECT_SIZE = $clog2(WORDS),
    parameter int READ_PORTS  = 2,
    parameter bit ZERO_REG    = 1'b1,
    parameter bit BYPASS      = 1'b1
) (
    input  logic                              clk_i,
    input  logic                              reset_ni,
    input  logic                              reg_we_ni,
    input  logic [DATA_WIDTH-1:0]             data_i,
    input  logic [SELECT_SIZE-1:0]            reg_dst_i,
    input  logic [READ_PORTS*SELECT_SIZE-1:0] reg_src_i,
    output logic [READ_PORTS*DATA_WIDTH-1:0]  src_o,
    output logic                              ready_o,
    output logic                              drop_o
);

    localparam logic [SELECT_SIZE-1:0] LAST_IDX = SELECT_SIZE'(WORDS - 1);
    localparam logic [SELECT_SIZE:0]   WORDS_W  = (SELECT_SIZE+1)'(WORDS);

    rf_state_e               state_q, state_d;
    logic [SELECT_SIZE-1:0]  clr_cnt_q, clr_cnt_d;
    logic                    drop_q, drop_d;
    logic [DATA_WIDTH-1:0]   bank_q [WORDS];

    logic                    bank_we;
    logic [SELECT_SIZE-1:0]  bank_waddr;
    logic [DATA_WIDTH-1:0]   bank_wdata;

    logic ready;
    logic wr_req;
    logic dst_valid;
    logic dst_zero;
    logic byp_en;

    // Reset low forces the file unready immediately, not one edge later.
    assign ready     = reset_ni && (state_q == READY);
    assign wr_req    = reset_ni && !reg_we_ni;
    assign dst_valid = ({1'b0, reg_dst_i} < WORDS_W);
    assign dst_zero  = ZERO_REG && (reg_dst_i == '0);
    assign byp_en    = BYPASS && ready && wr_req && dst_valid && !dst_zero;

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        drop_d     = 1'b0;
        bank_we    = 1'b0;
        bank_waddr = reg_dst_i;
        bank_wdata = data_i;
        case (state_q)
            CLEAR: begin
                // The single write port is owned by the clear walk here.
                bank_we    = reset_ni;
                bank_waddr = clr_cnt_q;
                bank_wdata = '0;
                clr_cnt_d  = clr_cnt_q + SELECT_SIZE'(1);
                drop_d     = wr_req;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = READY;
                    clr_cnt_d = '0;
                end
            end
            READY: begin
                bank_we = wr_req && dst_valid && !dst_zero;
                drop_d  = wr_req && !dst_valid;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            drop_q    <= drop_d;
        end
    end

    // No reset on the storage: contents are zeroed only by the clear walk.
    always_ff @(posedge clk_i) begin
        if (bank_we) begin
            bank_q[bank_waddr] <= bank_wdata;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        regfile_read_port #(
            .DATA_WIDTH  (DATA_WIDTH),
            .WORDS       (WORDS),
            .SELECT_SIZE (SELECT_SIZE),
            .ZERO_REG    (ZERO_REG)
        ) u_rd (
            .ready_i    (ready),
            .idx_i      (reg_src_i[p*SELECT_SIZE +: SELECT_SIZE]),
            .bank_i     (bank_q),
            .byp_en_i   (byp_en),
            .byp_idx_i  (reg_dst_i),
            .byp_data_i (data_i),
            .data_o     (src_o[p*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign ready_o = ready;
    assign drop_o  = drop_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a 4-port forwarding instance and a
// 1-port non-forwarding instance driven in lockstep against a model.
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we_n = 1'b1;
    logic [31:0] wdata = '0;
    logic [4:0]  dst = '0;
    logic [19:0] src_a = '0;
    logic [4:0]  src_b = '0;
    logic [127:0] out_a;
    logic [31:0] out_b;
    logic        ready_a, drop_a, ready_b, drop_b;

    always #5 clk = ~clk;

    register_file_mp #(
        .DATA_WIDTH(32), .WORDS(32), .READ_PORTS(4),
        .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) u_dut_a (
        .clk_i(clk), .reset_ni(rst_n), .reg_we_ni(we_n),
        .data_i(wdata), .reg_dst_i(dst), .reg_src_i(src_a),
        .src_o(out_a), .ready_o(ready_a), .drop_o(drop_a)
    );

    register_file_mp #(
        .DATA_WIDTH(32), .WORDS(32), .READ_PORTS(1),
        .ZERO_REG(1'b1), .BYPASS(1'b0)
    ) u_dut_b (
        .clk_i(clk), .reset_ni(rst_n), .reg_we_ni(we_n),
        .data_i(wdata), .reg_dst_i(dst), .reg_src_i(src_b),
        .src_o(out_b), .ready_o(ready_b), .drop_o(drop_b)
    );

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;

    logic [31:0] m_bank [32];
    int          m_left = 32;
    logic        m_drop = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0, 1, 2, 3: return out_a[sel*32 +: 32];
            4:          return out_b;
            5:          return {31'b0, ready_a};
            6:          return {31'b0, drop_a};
            7:          return {31'b0, ready_b};
            default:    return {31'b0, drop_b};
        endcase
    endfunction

    task automatic push(input int sel, input logic [31:0] exp,
                        input string name);
        exp_t e;
        e.sel = sel;
        e.exp = exp;
        e.tag = $sformatf("c%0d_%s", cyc, name);
        sb.push_back(e);
    endtask

    task automatic step(input logic rn, input logic wn,
                        input logic [4:0] d, input logic [31:0] dat,
                        input logic [4:0] s0, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [4:0] s3);
        logic [4:0]  s [4];
        logic        rdy;
        logic [31:0] e;
        exp_t        x;
        @(posedge clk);
        #1;
        rst_n = rn;
        we_n  = wn;
        dst   = d;
        wdata = dat;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        src_a = {s3, s2, s1, s0};
        src_b = s0;
        rdy = rn && (m_left == 0);
        for (int p = 0; p < 4; p++) begin
            if (!rdy || s[p] == 5'd0) e = '0;
            else if (!wn && d == s[p]) e = dat;
            else e = m_bank[s[p]];
            push(p, e, $sformatf("a_src%0d_x%0d", p, s[p]));
        end
        e = (!rdy || s0 == 5'd0) ? 32'd0 : m_bank[s0];
        push(4, e, $sformatf("b_src0_x%0d", s0));
        push(5, {31'b0, rdy}, "a_ready");
        push(6, {31'b0, m_drop}, "a_drop");
        push(7, {31'b0, rdy}, "b_ready");
        push(8, {31'b0, m_drop}, "b_drop");
        @(negedge clk);
        while (sb.size() > 0) begin
            x = sb.pop_front();
            chk(x.tag, observe(x.sel), x.exp);
        end
        if (!rn) begin
            m_left = 32;
            m_drop = 1'b0;
        end else begin
            m_drop = !wn && (m_left > 0);
            if (m_left > 0) begin
                m_bank[32 - m_left] = '0;
                m_left--;
            end else if (!wn && d != 5'd0) begin
                m_bank[d] = dat;
            end
        end
        cyc++;
    endtask

    task automatic idle(input logic [4:0] s0, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [4:0] s3);
        step(1'b1, 1'b1, 5'd0, 32'd0, s0, s1, s2, s3);
    endtask

    initial begin
        logic [4:0]  rd, ra;
        logic [31:0] rv;
        for (int i = 0; i < 32; i++) m_bank[i] = 32'hBAD0_0000 | i;

        repeat (3) step(1'b0, 1'b1, 5'd0, 32'd0, 5'd1, 5'd2, 5'd3, 5'd4);

        for (int k = 1; k <= 32; k++) begin
            step(1'b1, (k == 10) ? 1'b0 : 1'b1, 5'd7, 32'd1,
                 5'(k), 5'd7, 5'(k + 3), 5'd31);
        end

        for (int i = 0; i < 8; i++) begin
            idle(5'(4*i), 5'(4*i+1), 5'(4*i+2), 5'(4*i+3));
        end

        step(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5, 5'd5);
        idle(5'd5, 5'd5, 5'd5, 5'd5);

        step(1'b1, 1'b0, 5'd0, 32'h12345678, 5'd0, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0, 5'd7, 5'd7);
        idle(5'd7, 5'd0, 5'd0, 5'd0);

        step(1'b1, 1'b0, 5'd9, 32'hCAFEF00D, 5'd1, 5'd2, 5'd3, 5'd4);
        idle(5'd9, 5'd9, 5'd9, 5'd9);

        step(1'b1, 1'b0, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd9, 5'd3, 5'd5);
        idle(5'd3, 5'd3, 5'd9, 5'd5);
        step(1'b0, 1'b1, 5'd0, 32'd0, 5'd3, 5'd3, 5'd3, 5'd3);
        repeat (33) idle(5'd3, 5'd9, 5'd5, 5'd3);

        for (int i = 0; i < 60; i++) begin
            rd = 5'($urandom_range(0, 31));
            rv = $urandom;
            ra = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            step(1'b1, 1'($urandom_range(0, 1)), rd, rv, ra,
                 rd, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
